// File: rtl/detector_pkg.sv
// Shared helpers for the level detector: counter sizing for the debounce stage.
package detector_pkg;

  // Width of a counter that must hold 0..debounce; at least one bit.
  function automatic int cnt_width(input int debounce);
    if (debounce < 1) return 1;
    return $clog2(debounce + 1);
  endfunction

endpackage

// File: rtl/detector_sync_chain.sv
// N-flop synchroniser for an asynchronous single-bit level.
// Reset loads INIT into every stage so nothing ripples out on release.
module sync_chain #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_reg <= {STAGES{INIT}};
    else        chain_reg <= {chain_reg[STAGES-2:0], d};
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/detector.sv
// Synchronises and debounces an asynchronous level, then reports the stable
// level with registered one-cycle rising/falling/any-edge pulses.
module detector
  import detector_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   DEBOUNCE    = 4,
  parameter logic INIT        = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_level,
  output logic o_posedge,
  output logic o_negedge,
  output logic o_edge
);

  logic s;
  logic level_reg, level_next;
  logic pos_reg, neg_reg, edge_reg;
  logic pos_next, neg_next;

  sync_chain #(
    .STAGES (SYNC_STAGES),
    .INIT   (INIT)
  ) u_sync (
    .clk   (i_clk),
    .rst_n (i_rst),
    .d     (i_in),
    .q     (s)
  );

  generate
    if (DEBOUNCE == 0) begin : g_bypass
      always_comb level_next = s;
    end else begin : g_debounce
      localparam int            CW   = cnt_width(DEBOUNCE);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

      logic [CW-1:0] cnt_reg, cnt_next;

      // Any cycle where s agrees with the level restarts the count.
      always_comb begin
        cnt_next   = '0;
        level_next = level_reg;
        if (s != level_reg) begin
          if (cnt_reg == LAST) level_next = s;
          else                 cnt_next   = cnt_reg + 1'b1;
        end
      end

      always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) cnt_reg <= '0;
        else        cnt_reg <= cnt_next;
      end
    end
  endgenerate

  always_comb begin
    pos_next = level_next & ~level_reg;
    neg_next = ~level_next & level_reg;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      level_reg <= INIT;
      pos_reg   <= 1'b0;
      neg_reg   <= 1'b0;
      edge_reg  <= 1'b0;
    end else begin
      level_reg <= level_next;
      pos_reg   <= pos_next;
      neg_reg   <= neg_next;
      edge_reg  <= pos_next | neg_next;
    end
  end

  assign o_level   = level_reg;
  assign o_posedge = pos_reg;
  assign o_negedge = neg_reg;
  assign o_edge    = edge_reg;

endmodule

// File: tb/tb_detector.sv
// Scoreboard bench for detector: stimulus pushes expected pulse events,
// monitors pop and compare whenever a DUT shows a pulse.
module tb_detector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_in = 1'b1;
  logic b_in = 1'b0;
  logic a_lvl, a_pos, a_neg, a_edge;
  logic b_lvl, b_pos, b_neg, b_edge;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int   cyc;
    logic pos;
    logic neg;
    logic lvl;
  } ev_t;

  ev_t q_a[$];
  ev_t q_b[$];
  ev_t ea, eb;

  detector #(.SYNC_STAGES(2), .DEBOUNCE(4), .INIT(1'b0)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_in(a_in),
    .o_level(a_lvl), .o_posedge(a_pos), .o_negedge(a_neg), .o_edge(a_edge)
  );

  detector #(.SYNC_STAGES(2), .DEBOUNCE(0), .INIT(1'b0)) dut_byp (
    .i_clk(clk), .i_rst(rst_n), .i_in(b_in),
    .o_level(b_lvl), .o_posedge(b_pos), .o_negedge(b_neg), .o_edge(b_edge)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input int c, input logic p);
    ev_t e;
    e.cyc = c;
    e.pos = p;
    e.neg = ~p;
    e.lvl = p;
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_now(input string name, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, got, exp);
    end else
      $display("ok   %s cyc=%0d value=%b", name, cyc, got);
  endtask

  always @(negedge clk) begin
    if (a_pos || a_neg || a_edge) begin
      vectors++;
      if (q_a.size() == 0) begin
        miscompares++;
        $display("FAIL dflt_unexpected cyc=%0d got pos=%b neg=%b edge=%b lvl=%b expected no pulse",
                 cyc, a_pos, a_neg, a_edge, a_lvl);
      end else begin
        ea = q_a.pop_front();
        if (ea.cyc != cyc || a_pos !== ea.pos || a_neg !== ea.neg ||
            a_edge !== (ea.pos | ea.neg) || a_lvl !== ea.lvl) begin
          miscompares++;
          $display("FAIL dflt_pulse got cyc=%0d pos=%b neg=%b edge=%b lvl=%b expected cyc=%0d pos=%b neg=%b edge=1 lvl=%b",
                   cyc, a_pos, a_neg, a_edge, a_lvl, ea.cyc, ea.pos, ea.neg, ea.lvl);
        end else
          $display("ok   dflt_pulse cyc=%0d pos=%b neg=%b lvl=%b", cyc, a_pos, a_neg, a_lvl);
      end
    end
  end

  always @(negedge clk) begin
    if (b_pos || b_neg || b_edge) begin
      vectors++;
      if (q_b.size() == 0) begin
        miscompares++;
        $display("FAIL byp_unexpected cyc=%0d got pos=%b neg=%b edge=%b lvl=%b expected no pulse",
                 cyc, b_pos, b_neg, b_edge, b_lvl);
      end else begin
        eb = q_b.pop_front();
        if (eb.cyc != cyc || b_pos !== eb.pos || b_neg !== eb.neg ||
            b_edge !== (eb.pos | eb.neg) || b_lvl !== eb.lvl) begin
          miscompares++;
          $display("FAIL byp_pulse got cyc=%0d pos=%b neg=%b edge=%b lvl=%b expected cyc=%0d pos=%b neg=%b edge=1 lvl=%b",
                   cyc, b_pos, b_neg, b_edge, b_lvl, eb.cyc, eb.pos, eb.neg, eb.lvl);
        end else
          $display("ok   byp_pulse cyc=%0d pos=%b neg=%b lvl=%b", cyc, b_pos, b_neg, b_lvl);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got no finish expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    // Reset held with input high: nothing may leak through.
    a_in = 1'b1;
    step(3);
    check_now("rst_level", a_lvl, 1'b0);
    check_now("rst_pos", a_pos, 1'b0);
    check_now("rst_edge", a_edge, 1'b0);
    check_now("rst_byp_level", b_lvl, 1'b0);
    rst_n = 1'b1;
    q_a.push_back(mk(cyc + 6, 1'b1));
    step(10);

    // Clean fall then clean rise.
    a_in = 1'b0; q_a.push_back(mk(cyc + 6, 1'b0)); step(10);
    a_in = 1'b1; q_a.push_back(mk(cyc + 6, 1'b1)); step(10);

    // Return low, then a 3-cycle glitch (rejected) and a 4-cycle pulse (accepted).
    a_in = 1'b0; q_a.push_back(mk(cyc + 6, 1'b0)); step(10);
    a_in = 1'b1; step(3); a_in = 1'b0; step(10);
    check_now("glitch3_level", a_lvl, 1'b0);
    j = cyc;
    a_in = 1'b1;
    q_a.push_back(mk(j + 6, 1'b1));
    q_a.push_back(mk(j + 10, 1'b0));
    step(4); a_in = 1'b0; step(12);

    // Rise, then a bouncing fall.
    a_in = 1'b1; q_a.push_back(mk(cyc + 6, 1'b1)); step(10);
    j = cyc;
    a_in = 1'b0; step(1); a_in = 1'b1; step(1);
    a_in = 1'b0; step(1); a_in = 1'b1; step(1);
    a_in = 1'b0;
    q_a.push_back(mk(j + 10, 1'b0));
    step(12);
    check_now("bounce_level", a_lvl, 1'b0);

    // Bypass instance: toggle every 3 cycles.
    j = cyc;
    q_b.push_back(mk(j + 3, 1'b1));
    q_b.push_back(mk(j + 6, 1'b0));
    q_b.push_back(mk(j + 9, 1'b1));
    q_b.push_back(mk(j + 12, 1'b0));
    b_in = 1'b1; step(3); b_in = 1'b0; step(3);
    b_in = 1'b1; step(3); b_in = 1'b0; step(8);

    // Reset in the middle of a pending fall.
    a_in = 1'b1; q_a.push_back(mk(cyc + 6, 1'b1)); step(10);
    check_now("pre_rst_level", a_lvl, 1'b1);
    a_in = 1'b0; step(4);
    rst_n = 1'b0;
    #1;
    check_now("midrst_level", a_lvl, 1'b0);
    check_now("midrst_neg", a_neg, 1'b0);
    check_now("midrst_edge", a_edge, 1'b0);
    a_in = 1'b1; step(3);
    rst_n = 1'b1;
    q_a.push_back(mk(cyc + 6, 1'b1));
    step(12);

    vectors++;
    if (q_a.size() != 0) begin
      miscompares++;
      $display("FAIL dflt_missing got %0d events left expected 0", q_a.size());
    end else $display("ok   dflt_drained");
    vectors++;
    if (q_b.size() != 0) begin
      miscompares++;
      $display("FAIL byp_missing got %0d events left expected 0", q_b.size());
    end else $display("ok   byp_drained");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
